bram_stream_fifo: RTL and testbench

//  Single-clock streaming FIFO built around one DP_RAM16K (512x32) block RAM.

---
 rtl/qlf_k6n10_bram_pkg.sv | 13 +
 rtl/DP_RAM16K.sv | 32 +++
 rtl/bram_fifo_obuf.sv | 68 ++++++
 rtl/bram_stream_fifo.sv | 144 ++++++++++++++
 tb/tb_bram_stream_fifo.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/qlf_k6n10_bram_pkg.sv
// Shared constants for the k6n10 BRAM column wrappers.
// Holds the geometry of the DP_RAM16K primitive (512 x 32) and its registered read latency.
// It also holds the all-ones bit-enable word that turns on every data bit of a write.
package qlf_k6n10_bram_pkg;

  localparam int BRAM_DW     = 32;
  localparam int BRAM_AW     = 9;
  localparam int BRAM_DEPTH  = 512;
  localparam int BRAM_RD_LAT = 1;

  localparam logic [BRAM_DW-1:0] WENB_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/DP_RAM16K.sv
// Behavioural model of the DP_RAM16K dual-port block RAM (512 x 32).
// Both ports are synchronous. Writes happen on wclk when wen is low, and only
// the bits whose wenb bit is set are written. Reads happen on rclk when ren is low:
// the word at raddr is registered into d_out, which gives one cycle of read latency.
// Ports:
//   wclk, wen (active low), wenb[31:0], waddr[8:0], d_in[31:0]   write port
//   rclk, ren (active low), raddr[8:0], d_out[31:0]              read port
module DP_RAM16K
  import qlf_k6n10_bram_pkg::*;
(
  input  logic               wclk,
  input  logic               wen,
  input  logic [BRAM_DW-1:0] wenb,
  input  logic [BRAM_AW-1:0] waddr,
  input  logic [BRAM_DW-1:0] d_in,
  input  logic               rclk,
  input  logic               ren,
  input  logic [BRAM_AW-1:0] raddr,
  output logic [BRAM_DW-1:0] d_out
);

  logic [BRAM_DW-1:0] r_mem [BRAM_DEPTH];

  always_ff @(posedge wclk) begin
    if (!wen) r_mem[waddr] <= (r_mem[waddr] & ~wenb) | (d_in & wenb);
  end

  always_ff @(posedge rclk) begin
    if (!ren) d_out <= r_mem[raddr];
  end

endmodule

// File: rtl/bram_fifo_obuf.sv
// Output buffer: a 2-entry register FIFO that sits behind the BRAM read port.
// Entry 0 is the head and drives dout directly.
// Ports:
//   C     clock
//   R     async reset, active low
//   clr   sync clear, highest priority
//   push  write din into the tail
//   din   tail data
//   pop   remove the head; the caller only pops when cnt != 0
//   dout  head data
//   cnt   number of occupied entries (0..2)
module bram_fifo_obuf #(
  parameter int DATA_W = 32
) (
  input  logic              C,
  input  logic              R,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] r_d0;
  logic [DATA_W-1:0] r_d1;
  logic [1:0]        r_cnt;

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_cnt <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else if (clr) begin
      r_cnt <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= din;
          else               r_d1 <= din;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // The count is unchanged. With one entry, the new word replaces the
          // head. With two entries, the tail shifts to the head and the new
          // word becomes the tail.
          if (r_cnt == 2'd1) begin
            r_d0 <= din;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = r_d0;
  assign cnt  = r_cnt;

endmodule

// File: rtl/bram_stream_fifo.sv
// Single-clock streaming FIFO built on one DP_RAM16K (512 x 32).
// The block drives the RAM's active-low strobes and absorbs its one-cycle read
// latency with a 2-entry output buffer, so the consumer sees a 1 word/cycle
// valid/ready stream.
// Ports:
//   C            clock (drives both RAM ports)
//   R            async reset, active low
//   flush        sync clear of all FIFO state; RAM contents are left untouched
//   in_valid     producer word valid
//   in_ready     FIFO can accept (RAM not full)
//   in_data      producer word
//   out_valid    out_data holds a valid head word
//   out_ready    consumer accepts the head word
//   out_data     head word, taken from the output buffer register
//   level        registered total words held (RAM + in-flight read + output buffer)
//   almost_full  registered, level >= AFULL_LEVEL
module bram_stream_fifo
  import qlf_k6n10_bram_pkg::*;
#(
  parameter int AFULL_LEVEL = 500,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9
) (
  input  logic              C,
  input  logic              R,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   level,
  output logic              almost_full
);

  localparam int              CW      = ADDR_W + 1;
  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_C = CW'(AFULL_LEVEL);

  if (DATA_W != BRAM_DW) begin : g_bad_data_w
    $error("bram_stream_fifo: DATA_W must be 32 to match the RAM width");
  end
  if (ADDR_W != BRAM_AW || DEPTH != BRAM_DEPTH) begin : g_bad_addr_w
    $error("bram_stream_fifo: ADDR_W must be 9 to match the RAM depth");
  end
  if (BRAM_RD_LAT != 1) begin : g_bad_rd_lat
    $error("bram_stream_fifo: the single in-flight flag assumes one-cycle RAM reads");
  end

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [CW-1:0]     r_ram_cnt;
  logic              r_inflight;
  logic [CW-1:0]     r_level;
  logic              r_afull;

  logic              w_push;
  logic              w_pop;
  logic              w_rd_issue;
  logic [1:0]        w_obuf_cnt;
  logic [2:0]        w_obuf_sum;
  logic [1:0]        w_obuf_nxt;
  logic [CW-1:0]     w_ram_cnt_nxt;
  logic [CW-1:0]     w_level_nxt;
  logic              w_ram_wen;
  logic              w_ram_ren;
  logic [DATA_W-1:0] w_ram_dout;

  assign in_ready  = (r_ram_cnt < DEPTH_C);
  assign out_valid = (w_obuf_cnt != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Occupancy of the output buffer after this edge. It counts the word that
  // lands from an in-flight read and subtracts the word the consumer takes. A
  // read is issued only if this leaves room for the word it will return.
  assign w_obuf_sum = {1'b0, w_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_obuf_nxt = w_obuf_sum[1:0];
  assign w_rd_issue = (r_ram_cnt != '0) && (w_obuf_sum < 3'd2);

  assign w_ram_cnt_nxt = r_ram_cnt + CW'(w_push) - CW'(w_rd_issue);
  assign w_level_nxt   = w_ram_cnt_nxt + CW'(w_rd_issue) + CW'(w_obuf_nxt);

  // Strobes are gated by R, so the RAM sees no write or read while reset is held.
  // in_ready is 1 during reset and would otherwise let in_valid through.
  assign w_ram_wen = ~(w_push & R);
  assign w_ram_ren = ~(w_rd_issue & R);

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_level    <= '0;
      r_afull    <= 1'b0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_level    <= '0;
      r_afull    <= 1'b0;
    end else begin
      if (w_push)     r_wptr <= r_wptr + ADDR_W'(1);
      if (w_rd_issue) r_rptr <= r_rptr + ADDR_W'(1);
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_inflight <= w_rd_issue;
      r_level    <= w_level_nxt;
      r_afull    <= (w_level_nxt >= AFULL_C);
    end
  end

  assign level       = r_level;
  assign almost_full = r_afull;

  DP_RAM16K u_ram (
    .wclk  (C),
    .wen   (w_ram_wen),
    .wenb  (WENB_ALL),
    .waddr (r_wptr),
    .d_in  (in_data),
    .rclk  (C),
    .ren   (w_ram_ren),
    .raddr (r_rptr),
    .d_out (w_ram_dout)
  );

  // A flush clears the buffer with priority, so a read in flight during the
  // flush cycle is never captured.
  bram_fifo_obuf #(.DATA_W(DATA_W)) u_obuf (
    .C    (C),
    .R    (R),
    .clr  (flush),
    .push (r_inflight),
    .din  (w_ram_dout),
    .pop  (w_pop),
    .dout (out_data),
    .cnt  (w_obuf_cnt)
  );

endmodule

// File: tb/tb_bram_stream_fifo.sv
module tb_bram_stream_fifo;

  logic        C;
  logic        R;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [9:0]  level;
  logic        almost_full;

  int n_assert;
  int n_fail;

  bram_stream_fifo #(.AFULL_LEVEL(500), .DATA_W(32), .ADDR_W(9)) dut (
    .C           (C),
    .R           (R),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
      n_assert++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b want 0", almost_full); end
      n_assert++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      n_assert++; if (dut.w_ram_wen !== 1'b1) begin n_fail++; $display("FAIL rst_wen: got %b want 1", dut.w_ram_wen); end
      n_assert++; if (dut.w_ram_ren !== 1'b1) begin n_fail++; $display("FAIL rst_ren: got %b want 1", dut.w_ram_ren); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    R = 1'b1;
    tick();
    n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL rst_release_level: got %0d want 0", level); end
  endtask

  task automatic test_single_word();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    tick();                       // edge 0: push
    in_valid = 1'b0;
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e0_valid: got %b want 0", out_valid); end
    n_assert++; if (level !== 10'd1) begin n_fail++; $display("FAIL single_e0_level: got %0d want 1", level); end
    tick();                       // edge 1: read issued
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e1_valid: got %b want 0", out_valid); end
    n_assert++; if (level !== 10'd1) begin n_fail++; $display("FAIL single_e1_level: got %0d want 1", level); end
    tick();                       // edge 2: captured
    n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_e2_valid: got %b want 1", out_valid); end
    n_assert++; if (out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_data: got %h want a5a50001", out_data); end
    tick();                       // edge 3: popped
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e3_valid: got %b want 0", out_valid); end
    n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL single_e3_level: got %0d want 0", level); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    int acc;
    int exp;
    logic will_push;
    acc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 620; c++) begin
      in_data = acc;
      will_push = in_ready;
      tick();
      if (will_push) acc++;
      n_assert++; if (level !== 10'(acc)) begin n_fail++; $display("FAIL fill_level c=%0d: got %0d want %0d", c, level, acc); end
      n_assert++; if (almost_full !== (acc >= 500)) begin n_fail++; $display("FAIL fill_afull c=%0d: got %b want %b", c, almost_full, (acc >= 500)); end
      n_assert++; if (in_ready !== (acc < 514)) begin n_fail++; $display("FAIL fill_in_ready c=%0d: got %b want %b", c, in_ready, (acc < 514)); end
    end
    in_valid = 1'b0;
    n_assert++; if (acc != 514) begin n_fail++; $display("FAIL fill_accepted: got %0d want 514", acc); end
    exp = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (out_valid) begin
        n_assert++; if (out_data !== 32'(exp)) begin n_fail++; $display("FAIL drain_data: got %0d want %0d", out_data, exp); end
        exp++;
      end
      tick();
    end
    out_ready = 1'b0;
    n_assert++; if (exp != 514) begin n_fail++; $display("FAIL drain_count: got %0d want 514", exp); end
    n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", level); end
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int nin;
    int nout;
    int first;
    int bubbles;
    logic p;
    nin = 0; nout = 0; first = -1; bubbles = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 1600; c++) begin
      in_valid = (nin < 1500);
      in_data  = 32'h4000_0000 + nin;
      p = in_valid & in_ready;
      if (out_valid) begin
        n_assert++; if (out_data !== 32'h4000_0000 + nout) begin n_fail++; $display("FAIL stream_data: got %h want %h", out_data, 32'h4000_0000 + nout); end
        if (first < 0) first = c;
        nout++;
      end else if (first >= 0 && nout < 1500) begin
        bubbles++;
      end
      tick();
      if (p) nin++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_assert++; if (nout != 1500) begin n_fail++; $display("FAIL stream_count: got %0d want 1500", nout); end
    n_assert++; if (first != 3) begin n_fail++; $display("FAIL stream_first_valid: got cycle %0d want 3", first); end
    n_assert++; if (bubbles != 0) begin n_fail++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
    n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL stream_level: got %0d want 0", level); end
  endtask

  task automatic test_flush();
    bit seen;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hF0; tick();
    in_data = 32'hF1; tick();
    in_data = 32'hF2; tick();
    n_assert++; if (level !== 10'd3) begin n_fail++; $display("FAIL flush_pre_level: got %0d want 3", level); end
    n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    flush = 1'b1; in_data = 32'hF3; out_ready = 1'b1;
    #1;
    n_assert++; if (dut.w_ram_wen !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_push: wen got %b want 0", dut.w_ram_wen); end
    n_assert++; if (dut.w_ram_ren !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_issue: ren got %b want 0", dut.w_ram_ren); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL flush_level: got %0d want 0", level); end
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_valid: got %b want 0", out_valid); end
      n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL flush_stale_level: got %0d want 0", level); end
    end
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    n_assert++; if (!seen) begin n_fail++; $display("FAIL flush_repush_timeout: out_valid got 0 want 1"); end
    n_assert++; if (out_data !== 32'h1) begin n_fail++; $display("FAIL flush_repush_data: got %h want 1", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL flush_final_level: got %0d want 0", level); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic p;
    logic pp;
    for (int c = 0; c < 10000; c++) begin
      n_assert++; if (level !== 10'(q.size())) begin n_fail++; $display("FAIL rand_level c=%0d: got %0d want %0d", c, level, q.size()); end
      if (c == 5000) begin
        in_valid = 1'b0; out_ready = 1'b0;
        #2 R = 1'b0;
        #1;
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rand_rst_in_ready: got %b want 1", in_ready); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_rst_valid: got %b want 0", out_valid); end
        n_assert++; if (level !== 10'd0) begin n_fail++; $display("FAIL rand_rst_level: got %0d want 0", level); end
        n_assert++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rand_rst_data: got %h want 0", out_data); end
        n_assert++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rand_rst_afull: got %b want 0", almost_full); end
        q.delete();
        tick();
        R = 1'b1;
        continue;
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      p  = in_valid & in_ready;
      pp = out_valid & out_ready;
      if (pp) begin
        if (q.size() == 0) begin
          n_assert++; n_fail++; $display("FAIL rand_underflow c=%0d: got %h want no word", c, out_data);
        end else begin
          n_assert++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rand_data c=%0d: got %h want %h", c, out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      if (p) q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    R = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
